pipe_stage_chain: RTL
=====================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  - WIDTH, 64, payload bits per stage; legal range 1..256.
  - STAGES, 4, number of pipeline stages; legal range 2..8.
  - COMPACT, 0, stall mode: 0 = MIPS-style freeze, 1 = bubble-collapsing.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  synchronous, active-low reset.
  - in_valid  in  1  producer offers in_data.
  - in_data  in  WIDTH  payload entering stage 0.
  - in_ready  out  1  stage 0 accepts this cycle.
  - stall_req  in  STAGES  bit k requests stage k hold.
  - flush  in  STAGES  bit k kills stages 0..k.
  - out_valid  out  1  stage STAGES-1 offers out_data.
  - out_data  out  WIDTH  payload of stage STAGES-1.
  - out_ready  in  1  consumer accepts.
  - stage_valid  out  STAGES  per-stage valid bits.
  - stage_data  out  STAGES*WIDTH  per-stage payloads; stage k is at [k*WIDTH +: WIDTH].
  - occupancy  out  $clog2(STAGES+1)  count of valid stages.
REQ-003 Clock SHALL be clk; reset SHALL be rst, synchronous, active-low.

Function
REQ-004 Stage 0 SHALL be youngest and stage STAGES-1 oldest; each stage SHALL hold one valid bit plus WIDTH data.
REQ-005 hold[STAGES-1] SHALL equal stall_req[STAGES-1] | (valid[STAGES-1] & ~out_ready).
REQ-006 For k<STAGES-1 with COMPACT=0, hold[k] SHALL equal stall_req[k] | hold[k+1].
REQ-007 For k<STAGES-1 with COMPACT=1, hold[k] SHALL equal valid[k] & (stall_req[k] | hold[k+1]); an empty stage SHALL never hold and SHALL absorb its upstream neighbour.
REQ-008 A non-held stage k>0 SHALL load stage k-1 contents at the edge; if stage k-1 holds, stage k SHALL load a bubble (valid=0, data unchanged).
REQ-009 in_ready SHALL equal rst & ~hold[0] & ~|flush.
REQ-010 Stage 0 SHALL load {in_valid & in_ready, in_data} when not held.
REQ-011 flush[k] SHALL clear valid of stages 0..k at the next edge, overriding hold and load; stages >k SHALL advance normally; simultaneous flush bits SHALL act as the highest set bit.
REQ-012 out_valid SHALL equal valid[STAGES-1] & ~stall_req[STAGES-1] & ~flush[STAGES-1].
REQ-013 A transfer SHALL occur when out_valid & out_ready; the stage SHALL empty or refill in the same edge.
REQ-014 With no stalls, latency SHALL be STAGES edges from acceptance to out_valid, with throughput of one item per cycle, in order, with no loss or duplication.
REQ-015 occupancy SHALL be the registered popcount of the valid bits, consistent with stage_valid every cycle.
REQ-016 Data registers of invalid stages SHALL be don't-care externally, but SHALL be deterministic (not X) after reset.

Reset
REQ-017 With rst=0 at an edge, all valid bits SHALL clear to 0 and all data SHALL clear to 0.
REQ-018 While rst=0, in_ready SHALL be 0, and out_valid, stage_valid and occupancy SHALL read 0 after the reset edge.
REQ-019 Reset SHALL take priority over flush, stall and transfer, and SHALL discard in-flight data mid-operation.

Structure
REQ-020 A shared package pipe_pkg SHALL hold the default WIDTH/STAGES/COMPACT constants and the stall-mode enumeration.
REQ-021 One sub-module, pipe_stage (valid+data register with load/bubble/clear controls), SHALL be instantiated STAGES times by generate.
REQ-022 Hold and flush-mask computation SHALL reside in pipe_stage_chain.

Verification (STAGES=4, WIDTH=8)
REQ-023 Stream 0x01..0x08 with out_ready=1: first out_valid 4 cycles after the 0x01 accept, then 0x01..0x08 on consecutive cycles, with occupancy steady at 4.
REQ-024 COMPACT=0, stall_req[2]=1 for 3 cycles mid-stream: stages 0-2 frozen, stage 3 receives a bubble, in_ready=0 for 3 cycles, and the output sequence remains gap-only with no loss or duplication.
REQ-025 Stages hold 0xA0..0xA3 (0xA3 oldest), flush[1]=1 for one cycle: in_ready=0 that cycle; after the edge, stages 0,1 are invalid and 0xA2, 0xA3 continue; occupancy=2.
REQ-026 COMPACT=1, out_ready=0, input valid on alternate cycles: bubbles collapse, the chain fills to 4 valid entries, and in_ready drops only at occupancy=4.
REQ-027 rst=0 mid-stream for one edge, with flush[3]=1, stall_req[3]=1 and out_ready=1 applied together in the following cycle: reset clears all state (occupancy=0, out_valid=0), and in the following cycle out_valid=0 with no transfer.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and stall-mode encoding for the pipe_stage_chain slice.
//   DEF_WIDTH / DEF_STAGES / DEF_COMPACT : default parameter values
//   stall_mode_e                         : freeze vs. bubble-collapsing stall mode
package pipe_pkg;

  localparam int unsigned DEF_WIDTH   = 64;
  localparam int unsigned DEF_STAGES  = 4;
  localparam int unsigned DEF_COMPACT = 0;

  typedef enum logic {
    STALL_FREEZE  = 1'b0,
    STALL_COMPACT = 1'b1
  } stall_mode_e;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer handshake bundle for pipe_stage_chain.
//   in_valid/in_data/in_ready    : producer side, entering stage 0
//   out_valid/out_data/out_ready : consumer side, leaving the oldest stage
//   slave modport  : the pipeline itself
//   master modport : the environment driving and draining it
interface pipe_stage_chain_if
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a WIDTH-bit payload register.
//   clk, rst  : clock, synchronous active-low reset (clears valid and data)
//   load_i    : slot is not held and takes its upstream contents this edge
//   bubble_i  : upstream is holding; load an empty slot, keep old data
//   clear_i   : flush kill; forces valid low, wins over load
//   valid_i   : upstream valid bit
//   data_i    : upstream payload
//   valid_o   : registered valid bit
//   data_o    : registered payload
//   valid_d_o : next-state valid bit, used for registered occupancy
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             bubble_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_d_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: hold by default, load or bubble when released, kill last.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      if (bubble_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_i;
        data_d  = data_i;
      end
    end
    if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign valid_d_o = valid_d;

endmodule

// File: rtl/pipe_stage_chain.sv
// Linear valid/data pipeline with per-stage stall and flush controls.
// Stage 0 is youngest, stage STAGES-1 oldest and drives the output.
//   clk, rst    : clock, synchronous active-low reset
//   bus         : in_* / out_* handshake (slave modport)
//   stall_req   : bit k asks stage k to hold
//   flush       : bit k kills stages 0..k at the next edge
//   stage_valid : per-stage valid bits
//   stage_data  : per-stage payloads, stage k at [k*WIDTH +: WIDTH]
//   occupancy   : registered count of valid stages
// COMPACT=0 freezes everything upstream of a hold; COMPACT=1 lets empty
// stages keep absorbing so bubbles collapse out of the chain.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned STAGES  = DEF_STAGES,
  parameter  int unsigned COMPACT = DEF_COMPACT,
  localparam int unsigned OCC_W   = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_stage_chain_if.slave       bus,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic [OCC_W-1:0]        occupancy
);

  localparam stall_mode_e MODE = (COMPACT != 0) ? STALL_COMPACT : STALL_FREEZE;

  logic [STAGES-1:0] hold_c;
  logic [STAGES-1:0] kill_c;
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  data_w [STAGES];
  logic [OCC_W-1:0]  occupancy_q, occupancy_d;

  // Hold propagates from the output back toward stage 0.
  always_comb begin
    hold_c = '0;
    hold_c[STAGES-1] = stall_req[STAGES-1] | (stage_valid[STAGES-1] & ~bus.out_ready);
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      if (MODE == STALL_COMPACT) begin
        hold_c[k] = stage_valid[k] & (stall_req[k] | hold_c[k+1]);
      end else begin
        hold_c[k] = stall_req[k] | hold_c[k+1];
      end
    end
  end

  // Stage k dies if any flush bit at or above k is set, so the highest bit wins.
  always_comb begin
    kill_c = '0;
    kill_c[STAGES-1] = flush[STAGES-1];
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      kill_c[k] = flush[k] | kill_c[k+1];
    end
  end

  assign bus.in_ready  = rst & ~hold_c[0] & ~(|flush);
  assign bus.out_valid = stage_valid[STAGES-1] & ~stall_req[STAGES-1] & ~flush[STAGES-1];
  assign bus.out_data  = data_w[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_bubble;

    if (k == 0) begin : g_head
      assign ld_valid  = bus.in_valid & bus.in_ready;
      assign ld_data   = bus.in_data;
      assign ld_bubble = 1'b0;
    end else begin : g_body
      assign ld_valid  = stage_valid[k-1];
      assign ld_data   = data_w[k-1];
      assign ld_bubble = hold_c[k-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load_i    (~hold_c[k]),
      .bubble_i  (ld_bubble),
      .clear_i   (kill_c[k]),
      .valid_i   (ld_valid),
      .data_i    (ld_data),
      .valid_o   (stage_valid[k]),
      .data_o    (data_w[k]),
      .valid_d_o (valid_d[k])
    );

    assign stage_data[k*WIDTH +: WIDTH] = data_w[k];
  end

  // Popcount of next-state valids so occupancy tracks stage_valid each cycle.
  always_comb begin
    occupancy_d = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      occupancy_d = occupancy_d + OCC_W'(valid_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy = occupancy_q;

endmodule
